// File: rtl/fire_scheduler.sv
// Fire-enable scheduler for generated synchronous circuit models: picks which excited signals
// fire each cycle and flags quiescence/deadlock. Define SCHED_STEP_EN to add the `step` input.
module fire_scheduler #(
   parameter int unsigned N       = 8,
   parameter int unsigned TIMEOUT = 16,
   parameter logic [15:0] SEED    = 16'hACE1,
   parameter int unsigned CW      = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [1:0]    mode,
   input  logic [N-1:0]  excited,
   input  logic [N-1:0]  allow,
`ifdef SCHED_STEP_EN
   input  logic          step,
`endif
   output logic [N-1:0]  ena,
   output logic          busy,
   output logic          stable,
   output logic          halted,
   output logic [CW-1:0] fire_count
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned BW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [15:0] SeedEff = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [BW-1:0] BlkMax = BW'(TIMEOUT - 1);

   if (N < 2 || N > 256) begin : g_bad_n
      $error("fire_scheduler: N must be in 2..256");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("fire_scheduler: TIMEOUT must be >= 1");
   end

   typedef enum logic [1:0] {StIdle, StRun, StDone, StHalt} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [15:0]     lfsr_q, lfsr_d;
   logic [BW-1:0]   blk_q, blk_d;
   logic [CW-1:0]   fc_q, fc_d;

   logic            step_en;
   logic [N-1:0]    cand, mask, masked, pick_oh, sel;
   logic [255:0]    rep_full;
   logic [IW-1:0]   lfsr_start, pick_start, pick, ptr_next;
   logic [15:0]     lfsr_next;
   logic            run_act;

`ifdef SCHED_STEP_EN
   assign step_en = step;
`else
   assign step_en = 1'b1;
`endif

   // First set bit of c at or above s, wrapping past N-1 back to 0.
   function automatic logic [IW-1:0] first_from(input logic [N-1:0] c, input logic [IW-1:0] s);
      logic [IW-1:0] r;
      logic          found;
      int unsigned   j;
      r     = s;
      found = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         j = (32'(s) + k) % N;
         if (!found && c[IW'(j)]) begin
            found = 1'b1;
            r     = IW'(j);
         end
      end
      return r;
   endfunction

   assign rep_full   = {16{lfsr_q}};
   assign mask       = rep_full[N-1:0];
   assign lfsr_next  = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
   assign lfsr_start = IW'(32'(lfsr_q) % N);

   always_comb begin
      cand       = excited & allow;
      masked     = cand & mask;
      pick_start = (mode == 2'd0) ? ptr_q : lfsr_start;
      pick       = first_from(cand, pick_start);
      pick_oh    = N'(1) << pick;
      ptr_next   = (pick == IW'(N - 1)) ? '0 : pick + 1'b1;
      unique case (mode)
         2'd2:    sel = cand;
         2'd3:    sel = (masked != '0) ? masked : pick_oh;
         default: sel = pick_oh;
      endcase
      run_act = (state_q == StRun) && step_en;
      ena     = (run_act && cand != '0) ? sel : '0;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      lfsr_d  = lfsr_q;
      blk_d   = blk_q;
      fc_d    = fc_q;
      unique case (state_q)
         StRun: begin
            if (step_en) begin
               lfsr_d = lfsr_next;
               if (excited == '0) begin
                  state_d = StDone;
               end else if (cand == '0) begin
                  if (blk_q == BlkMax) state_d = StHalt;
                  else                 blk_d   = blk_q + 1'b1;
               end else begin
                  blk_d = '0;
                  if (mode == 2'd0) ptr_d = ptr_next;
                  if (fc_q != '1)   fc_d  = fc_q + 1'b1;
               end
            end
         end
         default: begin
            if (start) begin
               state_d = StRun;
               fc_d    = '0;
               blk_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         lfsr_q  <= SeedEff;
         blk_q   <= '0;
         fc_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         lfsr_q  <= lfsr_d;
         blk_q   <= blk_d;
         fc_q    <= fc_d;
      end
   end

   assign busy       = (state_q == StRun);
   assign stable     = (state_q == StDone);
   assign halted     = (state_q == StHalt);
   assign fire_count = fc_q;

endmodule

// File: tb/tb_fire_scheduler.sv
// Self-checking bench for fire_scheduler: directed scenarios plus randomized traffic compared
// against a behavioural model of the scheduling rules.
module tb_fire_scheduler;
   localparam int TO = 4;
   localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2, S_HALT = 3;

   logic        clk = 1'b0;
   logic        reset, start, step;
   logic [1:0]  mode;
   logic [7:0]  excited, allow, ena;
   logic        busy, stable, halted;
   logic [15:0] fire_count;

   int total = 0;
   int bad   = 0;

   int          m_st, m_ptr, m_blk, m_fc;
   logic [15:0] m_lfsr;

   fire_scheduler #(.N(8), .TIMEOUT(TO), .SEED(16'hACE1), .CW(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .mode       (mode),
      .excited    (excited),
      .allow      (allow),
`ifdef SCHED_STEP_EN
      .step       (step),
`endif
      .ena        (ena),
      .busy       (busy),
      .stable     (stable),
      .halted     (halted),
      .fire_count (fire_count)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_st = S_IDLE; m_ptr = 0; m_blk = 0; m_fc = 0; m_lfsr = 16'hACE1;
   endtask

   function automatic int m_find(input logic [7:0] c, input int s);
      int j;
      for (int k = 0; k < 8; k++) begin
         j = (s + k) % 8;
         if (c[j[2:0]]) return j;
      end
      return 0;
   endfunction

   function automatic logic [7:0] m_ena();
      logic [7:0] c, r;
      if (m_st != S_RUN || !step) return 8'h00;
      c = excited & allow;
      if (c == 8'h00) return 8'h00;
      case (mode)
         2'd0: return 8'h01 << m_find(c, m_ptr);
         2'd1: return 8'h01 << m_find(c, int'(m_lfsr) % 8);
         2'd2: return c;
         default: begin
            r = c & m_lfsr[7:0];
            if (r != 8'h00) return r;
            return 8'h01 << m_find(c, int'(m_lfsr) % 8);
         end
      endcase
   endfunction

   task automatic m_adv();
      logic [7:0] c;
      if (!reset) begin m_reset(); return; end
      c = excited & allow;
      if (m_st == S_RUN) begin
         if (!step) return;
         m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
         if (excited == 8'h00) m_st = S_DONE;
         else if (c == 8'h00) begin
            m_blk++;
            if (m_blk >= TO) m_st = S_HALT;
         end else begin
            m_blk = 0;
            if (mode == 2'd0) m_ptr = (m_find(c, m_ptr) + 1) % 8;
            if (m_fc < 65535) m_fc++;
         end
      end else if (start) begin
         m_st = S_RUN; m_fc = 0; m_blk = 0;
      end
   endtask

   // Check all outputs against the model, then advance one clock edge.
   task automatic tick(input string tag);
      logic [7:0] e;
      #1;
      e = m_ena();
      chk({tag, ".ena"}, 32'(ena), 32'(e));
      chk({tag, ".busy"}, 32'(busy), 32'(m_st == S_RUN));
      chk({tag, ".stable"}, 32'(stable), 32'(m_st == S_DONE));
      chk({tag, ".halted"}, 32'(halted), 32'(m_st == S_HALT));
      chk({tag, ".fire_count"}, 32'(fire_count), 32'(m_fc));
      if (e != 8'h00 && mode < 2'd2) chk({tag, ".onehot"}, 32'($countones(ena)), 32'd1);
      m_adv();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] seq [4];
   int r;

   initial begin
      seq = '{8'h04, 8'h20, 8'h80, 8'h04};
      reset = 1'b0; start = 1'b0; mode = 2'd0; excited = 8'h00; allow = 8'h00; step = 1'b1;
      m_reset();
      #3;
      tick("reset"); tick("reset");
      reset = 1'b1;

      // Round-robin over a fixed excited pattern.
      mode = 2'd0; excited = 8'hA4; allow = 8'hFF; start = 1'b1;
      tick("m0_start");
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("m0_seq", 32'(ena), 32'(seq[i]));
         tick("m0");
      end
      chk("m0_count", 32'(fire_count), 32'd4);

      // Asynchronous reset in the middle of a run.
      excited = 8'hFF;
      tick("pre_rst"); tick("pre_rst");
      reset = 1'b0;
      #1;
      chk("rst_mid.ena", 32'(ena), 32'd0);
      chk("rst_mid.busy", 32'(busy), 32'd0);
      m_reset();
      tick("rst_mid");
      reset = 1'b1;

      // Random single pick from the reset LFSR value.
      mode = 2'd1; excited = 8'hFF; allow = 8'hFF; start = 1'b1;
      tick("m1_start");
      start = 1'b0;
      #1;
      chk("m1_first", 32'(ena), 32'h02);
      for (int i = 0; i < 1000; i++) tick("m1");
      excited = 8'h00;
      tick("m1_quiet");
      #1;
      chk("m1_done", 32'(stable), 32'd1);

      // Fire all excited candidates, then quiesce.
      mode = 2'd2; excited = 8'h0F; allow = 8'h05; start = 1'b1;
      tick("m2_start");
      start = 1'b0;
      #1;
      chk("m2_ena", 32'(ena), 32'h05);
      tick("m2");
      excited = 8'h00;
      tick("m2_quiet");
      #1;
      chk("m2_stable", 32'(stable), 32'd1);
      chk("m2_busy", 32'(busy), 32'd0);
      chk("m2_ena0", 32'(ena), 32'd0);

      // Deadlock: the only excited signal is blocked.
      mode = 2'd0; excited = 8'h10; allow = 8'hEF; start = 1'b1;
      tick("dl_start");
      start = 1'b0;
      for (int i = 0; i < 3; i++) tick("dl");
      #1;
      chk("dl_not_yet", 32'(halted), 32'd0);
      tick("dl_last");
      chk("dl_halted", 32'(halted), 32'd1);
      chk("dl_count", 32'(fire_count), 32'd0);

`ifdef SCHED_STEP_EN
      mode = 2'd0; excited = 8'hA4; allow = 8'hFF; start = 1'b1;
      tick("st_start");
      start = 1'b0;
      tick("st_run");
      step = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("st_hold.ena", 32'(ena), 32'd0);
         chk("st_hold.count", 32'(fire_count), 32'd1);
         tick("st_hold");
      end
      step = 1'b1;
      tick("st_resume");
      chk("st_resume.count", 32'(fire_count), 32'd2);
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 800; i++) begin
         mode  = 2'($urandom_range(0, 3));
         r     = int'($urandom_range(0, 9));
         excited = (r == 0) ? 8'h00 : 8'($urandom);
         r     = int'($urandom_range(0, 3));
         allow = (r == 0) ? 8'hFF : 8'($urandom);
         start = ($urandom_range(0, 3) == 0);
         reset = ($urandom_range(0, 99) != 0);
         if (!reset) m_reset();
         tick("rand");
      end
      reset = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
